// File: rtl/me_sad_engine.sv
// me_sad_engine: streaming sum-of-absolute-differences motion search engine
//
// Accepts one column pair per handshake (current macroblock column and the
// matching search-window candidate column), accumulates the block SAD over
// MACRO_DIM columns per candidate, and reports the minimum SAD and its index
// after NUM_CAND candidates.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   start        - pulse in IDLE begins a search
//   in_valid     - column pair present on pixel inputs
//   in_ready     - high while searching (RUN)
//   pixel_cpr_in - current-macroblock column, MACRO_DIM samples
//   pixel_spr_in - candidate column, MACRO_DIM samples
//   valid        - one-cycle pulse, min_sad/min_idx valid
//   min_sad      - minimum block SAD found
//   min_idx      - candidate index of min_sad (earliest on ties)
//
// Build option:
//   ME_EARLY_EXIT_EN - finish the search as soon as a candidate SAD is zero
module me_sad_engine #(
    parameter  int MACRO_DIM = 16,
    parameter  int NUM_CAND  = 4,
    parameter  int PIXEL_W   = 8,
    localparam int SAD_W     = PIXEL_W + 2 * $clog2(MACRO_DIM),
    localparam int IDX_W     = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] pixel_cpr_in [0:MACRO_DIM-1],
    input  logic [PIXEL_W-1:0] pixel_spr_in [0:MACRO_DIM-1],
    output logic               valid,
    output logic [SAD_W-1:0]   min_sad,
    output logic [IDX_W-1:0]   min_idx
);
    localparam int COL_W = $clog2(MACRO_DIM);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [SAD_W-1:0] r_acc, r_run_min, r_min_sad, w_col_sad, w_cand_sad;
    logic [IDX_W-1:0] r_cand, r_run_idx, r_min_idx;
    logic [COL_W-1:0] r_col;
    logic             w_accept, w_col_end, w_better, w_zero, w_last, w_finish;

    always_comb begin
        w_col_sad = '0;
        for (int k = 0; k < MACRO_DIM; k++)
            w_col_sad = w_col_sad + SAD_W'(pixel_cpr_in[k] > pixel_spr_in[k] ?
                        pixel_cpr_in[k] - pixel_spr_in[k] : pixel_spr_in[k] - pixel_cpr_in[k]);
    end

    assign w_cand_sad = r_acc + w_col_sad;
    assign w_accept   = in_valid && r_state == RUN;
    assign w_col_end  = w_accept && r_col == COL_W'(MACRO_DIM - 1);
    // strict compare keeps the earlier candidate on ties
    assign w_better   = w_cand_sad < r_run_min;
`ifdef ME_EARLY_EXIT_EN
    assign w_zero     = w_cand_sad == '0;
`else
    assign w_zero     = 1'b0;
`endif
    assign w_last     = r_cand == IDX_W'(NUM_CAND - 1) || w_zero;
    assign w_finish   = w_col_end && w_last;

    assign in_ready = r_state == RUN;
    assign valid    = r_state == DONE;
    assign min_sad  = r_min_sad;
    assign min_idx  = r_min_idx;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_finish ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_col     <= '0;
            r_cand    <= '0;
            r_run_min <= '0;
            r_run_idx <= '0;
            r_min_sad <= '0;
            r_min_idx <= '0;
        end else if (r_state == IDLE && start) begin
            r_acc     <= '0;
            r_col     <= '0;
            r_cand    <= '0;
            r_run_min <= '1;
            r_run_idx <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_acc <= '0;
                r_col <= '0;
                if (w_better) begin
                    r_run_min <= w_cand_sad;
                    r_run_idx <= r_cand;
                end
                if (!w_last) r_cand <= r_cand + 1'b1;
                if (w_last) begin
                    r_min_sad <= w_better ? w_cand_sad : r_run_min;
                    r_min_idx <= w_better ? r_cand : r_run_idx;
                end
            end else begin
                r_acc <= w_cand_sad;
                r_col <= r_col + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_me_sad_engine.sv
// tb_me_sad_engine: randomized and directed checks of me_sad_engine against a block-level SAD model
module tb_me_sad_engine;
    localparam int M  = 16;
    localparam int NC = 4;

    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] cpr [0:M-1];
    logic [7:0] spr [0:M-1];
    logic       valid;
    logic [15:0] min_sad;
    logic [1:0]  min_idx;

    me_sad_engine #(.MACRO_DIM(M), .NUM_CAND(NC), .PIXEL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_cpr_in(cpr), .pixel_spr_in(spr), .valid(valid),
        .min_sad(min_sad), .min_idx(min_idx)
    );

    always #5 clk = ~clk;

    logic [7:0] cur  [M][M];
    logic [7:0] cand [NC][M][M];

    int errors = 0;
    int checks = 0;

    logic        exp_ready = 0;
    logic        exp_valid = 0;
    logic [15:0] exp_min_sad = 0;
    logic [1:0]  exp_min_idx = 0;

    int unsigned m_sad;
    int          m_idx;
    int          m_cols;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("valid", 32'(valid), 32'(exp_valid));
        chk("min_sad", 32'(min_sad), 32'(exp_min_sad));
        chk("min_idx", 32'(min_idx), 32'(exp_min_idx));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned block_sad(int c);
        int unsigned s = 0;
        for (int j = 0; j < M; j++)
            for (int k = 0; k < M; k++)
                s += (cur[j][k] > cand[c][j][k]) ? cur[j][k] - cand[c][j][k] : cand[c][j][k] - cur[j][k];
        return s;
    endfunction

    task automatic model();
        int unsigned s;
        m_sad  = 32'hFFFF_FFFF;
        m_idx  = 0;
        m_cols = 0;
        for (int c = 0; c < NC; c++) begin
            s = block_sad(c);
            m_cols += M;
            if (s < m_sad) begin
                m_sad = s;
                m_idx = c;
            end
`ifdef ME_EARLY_EXIT_EN
            if (s == 0) break;
`endif
        end
    endtask

    task automatic fill_const(int cv, int c0, int c1, int c2, int c3);
        int cv_arr [NC];
        cv_arr = '{c0, c1, c2, c3};
        for (int j = 0; j < M; j++)
            for (int k = 0; k < M; k++) begin
                cur[j][k] = 8'(cv);
                for (int c = 0; c < NC; c++) cand[c][j][k] = 8'(cv_arr[c]);
            end
    endtask

    task automatic fill_random();
        int t;
        for (int j = 0; j < M; j++)
            for (int k = 0; k < M; k++) cur[j][k] = 8'($urandom);
        for (int c = 0; c < NC; c++) begin
            t = $urandom_range(0, 3);
            for (int j = 0; j < M; j++)
                for (int k = 0; k < M; k++)
                    cand[c][j][k] = (t == 1) ? cur[j][k] :
                                    (t == 2 && c > 0) ? cand[c-1][j][k] :
                                    (t == 3) ? 8'(cur[j][k] ^ 8'($urandom_range(0, 3))) : 8'($urandom);
        end
    endtask

    task automatic drive_col(int n);
        for (int k = 0; k < M; k++) begin
            cpr[k] = cur[n % M][k];
            spr[k] = cand[n / M][n % M][k];
        end
    endtask

    task automatic junk_col();
        for (int k = 0; k < M; k++) begin
            cpr[k] = 8'($urandom);
            spr[k] = 8'($urandom);
        end
    endtask

    task automatic run_search(int gap_mode, bit poke_start);
        model();
        start = 1;
        step();
        start = 0;
        exp_ready = 1;
        for (int n = 0; n < m_cols; n++) begin
            if ((gap_mode == 1 && n > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 0;
                junk_col();
                step();
            end
            in_valid = 1;
            drive_col(n);
            if (poke_start && n == 5) start = 1;
            step();
            start = 0;
        end
        in_valid = 0;
        exp_ready = 0;
        exp_valid = 1;
        exp_min_sad = 16'(m_sad);
        exp_min_idx = 2'(m_idx);
        step();
        exp_valid = 0;
        step();
    endtask

    initial begin
        junk_col();
        repeat (3) step();
        rst = 0;
        step();

        fill_const(8'h10, 8'h10, 8'h11, 8'h12, 8'h13);
        model();
        chk("pin_031_sad", m_sad, 0);
        chk("pin_031_idx", 32'(m_idx), 0);
        run_search(0, 0);

        fill_const(8'h10, 8'h12, 8'h11, 8'h11, 8'h14);
        model();
        chk("pin_032_sad", m_sad, 256);
        chk("pin_032_idx", 32'(m_idx), 1);
        chk("pin_032_cols", 32'(m_cols), 64);
        run_search(0, 0);
        chk("dut_032_sad", 32'(min_sad), 256);
        run_search(1, 0);
        chk("dut_033_idx", 32'(min_idx), 1);

        fill_const(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        model();
        chk("pin_034_sad", m_sad, 32'hFF00);
        run_search(0, 1);
        chk("dut_034_sad", 32'(min_sad), 32'hFF00);

        fill_const(8'h10, 8'h12, 8'h11, 8'h11, 8'h14);
        start = 1;
        step();
        start = 0;
        exp_ready = 1;
        for (int n = 0; n < 20; n++) begin
            in_valid = 1;
            drive_col(n);
            step();
        end
        in_valid = 0;
        rst = 1;
        exp_ready = 0;
        exp_min_sad = 0;
        exp_min_idx = 0;
        step();
        step();
        rst = 0;
        step();
        run_search(0, 0);
        chk("dut_035_sad", 32'(min_sad), 256);

        fill_const(8'h10, 8'h13, 8'h10, 8'h11, 8'h12);
        model();
`ifdef ME_EARLY_EXIT_EN
        chk("pin_036_cols", 32'(m_cols), 32);
`else
        chk("pin_036_cols", 32'(m_cols), 64);
`endif
        run_search(2, 0);
        chk("dut_036_idx", 32'(min_idx), 1);

        for (int r = 0; r < 10; r++) begin
            fill_random();
            run_search($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
